// File: rtl/chip_select.sv
// Wishbone peripheral address decoder with one-shot, wait-stated ack.
// Optional address-range masking is enabled by CHIP_SELECT_MASK_EN.
//
// Parameters:
//   ADDR  - peripheral select value (lower WIDTH bits compared)
//   WIDTH - width of the address compare field
//   WAIT  - extra wait cycles before ack (0..15)
//   MASK  - compare mask (only when CHIP_SELECT_MASK_EN is defined)
// Ports:
//   wb_ck  - bus clock, all state on rising edge
//   wb_rst - asynchronous active-low reset
//   addr   - decoded address field
//   wb_cyc - bus cycle valid from CPU
//   ack    - registered one-cycle acknowledge
//   cyc    - combinational peripheral-selected strobe
module chip_select #(
  parameter int unsigned ADDR  = 0,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WAIT  = 0
`ifdef CHIP_SELECT_MASK_EN
  ,
  parameter logic [WIDTH-1:0] MASK = '1
`endif
) (
  input  logic             wb_ck,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             wb_cyc,
  output logic             ack,
  output logic             cyc
);

  if (WAIT > 15) begin : g_bad_wait
    $error("chip_select: WAIT must be 0..15");
  end

  localparam logic [WIDTH-1:0] SEL = WIDTH'(ADDR);
  localparam logic [3:0] WAIT_M1 =
    (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       match;

`ifdef CHIP_SELECT_MASK_EN
  assign match = (addr & MASK) == (SEL & MASK);
`else
  assign match = (addr == SEL);
`endif

  // Held low during reset so a selected read mux never sees a
  // peripheral that is still being reset.
  assign cyc = wb_cyc & match & wb_rst;

  // Decoded straight from the state register: no input-to-ack path.
  assign ack = (state == ST_ACK);

  always_ff @(posedge wb_ck or negedge wb_rst) begin
    if (!wb_rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (cyc) begin
          if (WAIT == 0) begin
            state_nx = ST_ACK;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = WAIT_M1;
          end
        end
      end
      ST_WAIT: begin
        // Losing the select mid-wait aborts without an ack.
        if (!cyc) begin
          state_nx = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_ACK: begin
        state_nx = cyc ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        // A held cycle must drop before it can be acked again.
        if (!cyc) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chip_select.sv
// Randomised self-checking bench for chip_select.
// Model: an ack is due one cycle after a select run reaches WAIT+1.
module tb_chip_select;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h70;
  logic       wb_cyc = 1'b1;

  logic ack0, cyc0, ack3, cyc3, ack15, cyc15;

  int errs = 0;
  int checks = 0;
  int run = 0;
  int runm = 0;

  always #5 clk = ~clk;

  chip_select #(.ADDR(8'h70), .WIDTH(8), .WAIT(0)) dut0 (
    .wb_ck(clk), .wb_rst(rst_n), .addr(addr),
    .wb_cyc(wb_cyc), .ack(ack0), .cyc(cyc0)
  );

  chip_select #(.ADDR(8'h70), .WIDTH(8), .WAIT(3)) dut3 (
    .wb_ck(clk), .wb_rst(rst_n), .addr(addr),
    .wb_cyc(wb_cyc), .ack(ack3), .cyc(cyc3)
  );

  chip_select #(.ADDR(8'h70), .WIDTH(8), .WAIT(15)) dut15 (
    .wb_ck(clk), .wb_rst(rst_n), .addr(addr),
    .wb_cyc(wb_cyc), .ack(ack15), .cyc(cyc15)
  );

`ifdef CHIP_SELECT_MASK_EN
  logic ackm, cycm;
  chip_select #(
    .ADDR(8'h70), .WIDTH(8), .WAIT(0), .MASK(8'hF0)
  ) dutm (
    .wb_ck(clk), .wb_rst(rst_n), .addr(addr),
    .wb_cyc(wb_cyc), .ack(ackm), .cyc(cycm)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check cyc, then check ack
  // just after the rising edge that ends the cycle.
  task automatic step(input logic [7:0] a, input logic c,
                      input logic r);
    bit m;
    bit mm;
    @(negedge clk);
    addr = a;
    wb_cyc = c;
    rst_n = r;
    #1;
    m  = r && c && (a == 8'h70);
    mm = r && c && ((a & 8'hF0) == 8'h70);
    chk("cyc0", 32'(cyc0), 32'(m));
    chk("cyc3", 32'(cyc3), 32'(m));
    chk("cyc15", 32'(cyc15), 32'(m));
    run  = m ? run + 1 : 0;
    runm = mm ? runm + 1 : 0;
`ifdef CHIP_SELECT_MASK_EN
    chk("cycm", 32'(cycm), 32'(mm));
`endif
    @(posedge clk);
    #1;
    chk("ack0", 32'(ack0), 32'(run == 1));
    chk("ack3", 32'(ack3), 32'(run == 4));
    chk("ack15", 32'(ack15), 32'(run == 16));
`ifdef CHIP_SELECT_MASK_EN
    chk("ackm", 32'(ackm), 32'(runm == 1));
`endif
  endtask

  // Reset asserted between clock edges must clear ack and cyc at once.
  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack3", 32'(ack3), 32'd0);
    chk("rst_ack15", 32'(ack15), 32'd0);
    chk("rst_cyc0", 32'(cyc0), 32'd0);
    run  = 0;
    runm = 0;
  endtask

  initial begin
    logic [7:0] pool [5];
    logic [7:0] a;
    logic c;
    logic r;
    pool[0] = 8'h70;
    pool[1] = 8'h71;
    pool[2] = 8'h7C;
    pool[3] = 8'h80;
    pool[4] = 8'h70;

    repeat (2) step(8'h70, 1'b1, 1'b0);
    chk("reset_ack", 32'(ack0), 32'd0);

    repeat (3) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);

    repeat (10) step(8'h71, 1'b1, 1'b1);
    step(8'h71, 1'b0, 1'b1);

    repeat (6) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);
    repeat (2) step(8'h70, 1'b1, 1'b1);
    repeat (3) step(8'h70, 1'b0, 1'b1);

    repeat (2) begin
      repeat (2) step(8'h70, 1'b1, 1'b1);
      step(8'h70, 1'b0, 1'b1);
    end
    step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);

    repeat (2) step(8'h70, 1'b1, 1'b1);
    mid_reset();
    step(8'h70, 1'b1, 1'b0);
    repeat (5) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);
    step(8'h70, 1'b1, 1'b1);
    mid_reset();
    step(8'h70, 1'b1, 1'b0);
    repeat (3) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);

    repeat (3) step(8'h70, 1'b1, 1'b1);
    step(8'h71, 1'b1, 1'b1);
    repeat (2) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);

    repeat (20) step(8'h70, 1'b1, 1'b1);
    step(8'h70, 1'b0, 1'b1);

    repeat (2) step(8'h7C, 1'b1, 1'b1);
    step(8'h7C, 1'b0, 1'b1);
    repeat (3) step(8'h80, 1'b1, 1'b1);
    step(8'h80, 1'b0, 1'b1);

    a = 8'h70;
    c = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(5) == 0) c = ~c;
      if ($urandom_range(9) == 0) begin
        if ($urandom_range(4) == 0) a = 8'($urandom);
        else a = pool[$urandom_range(4)];
      end
      r = ($urandom_range(49) != 0);
      step(a, c, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
